yuv_to_rgb_unit: RTL and testbench
==================================

# yuv_to_rgb_unit

Serial YUV→RGB colour-space converter: the decode direction of the team's RGB→YUV datapath, restoring 8-bit RGB pixels from 9-bit-carried Y/U/V samples, with U and V offset by 128. One shared multiplier is time-multiplexed by an internal FSM, and pixels move over valid/ready handshakes on both sides. It sits downstream of YUV storage and processing, feeding the display/output path.

## Interface
- `BITS`, 9, data word width of every pixel port (sample value in bits [7:0]; bit 8 carried for compatibility)
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-high reset; `rst_n`=1 at a rising edge resets the block (name kept for codebase consistency; polarity is high)
- `inportY`, `inportU`, `inportV`  in  BITS each  input pixel; bits [7:0] used, bit 8 ignored
- `in_valid`  in  1  input pixel present
- `in_ready`  out  1  block can accept; combinational, =1 exactly when FSM is IDLE
- `outportR`, `outportG`, `outportB`  out  BITS each  registered result, 0..255, bit 8 always 0
- `out_valid`  out  1  registered; result on outport* is valid
- `out_ready`  in  1  downstream accepts result

## Operation
- Arithmetic, with du=U−128 and dv=V−128 as signed 9-bit values (−128..127), internal accumulators 18-bit signed:
  - R = clamp(Y + ((359·dv) >>> 8))
  - G = clamp(Y − ((88·du + 183·dv) >>> 8))
  - B = clamp(Y + ((454·du) >>> 8))
- `>>>` is an arithmetic shift, i.e. floor toward −∞.
- clamp: values <0 → 0; values >255 → 255.
- One 9×9-bit signed coefficient multiplier, shared; coefficients are constants selected by the FSM state.
- FSM states: IDLE → MUL_R → MUL_GU → MUL_GV → MUL_B → FIN → DONE → IDLE.
  - IDLE: on in_valid (in_ready=1), latch Y, du and dv, then go to MUL_R.
  - MUL_R: the R term is formed.
  - MUL_GU: 88·du is formed.
  - MUL_GV: 183·dv is formed and accumulated with 88·du.
  - MUL_B: the B term is formed.
  - FIN: add Y, clamp, load outportR/G/B, set out_valid.
  - DONE: hold outputs. On out_ready, clear out_valid and go to IDLE.
- Inputs presented while in_ready=0 are ignored; no buffering.
- Outputs and out_valid remain stable while out_valid=1 and out_ready=0.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values: outportR/G/B=0, out_valid=0, FSM=IDLE (so in_ready=1 in the cycle after the reset edge), all internal registers 0.
- Latency: accept edge = edge 0; out_valid=1 and results valid after edge 5.
- With out_ready held 1, the handshake occurs at edge 6 and in_ready=1 after it. The next accept is at edge 7 at the earliest, giving a throughput of 1 pixel per 7 cycles.
- Reset mid-operation (any state) takes priority: the in-flight pixel is discarded, values return to reset values, and no partial result is emitted.
- Reset coincident with an input or output handshake: reset wins; the handshake does not take effect.

## Test plan
- Y=128, U=128, V=128 accepted at edge 0 → out_valid rises after edge 5 (not 4, not 6); R=G=B=128; in_ready=0 in MUL_R..DONE.
- Y=76, U=84, V=255 → R=254, G=1, B=0 (checks floor shift and low clamp on B).
- Y=255, U=255, V=255 → R=255 (high clamp), G=121, B=255. Y=0, U=0, V=0 → R=0, G=136, B=0 (negative floor plus clamp).
- Backpressure: complete one pixel, hold out_ready=0 for 10 cycles while toggling in_valid and changing inports.
  - Required: outputs stable, out_valid=1, in_ready=0, no new pixel accepted.
  - Then assert out_ready=1: out_valid=0 and in_ready=1 after that edge.
- Reset mid-operation: assert rst_n=1 for one cycle while in MUL_GV.
  - Required: next cycle out_valid=0, outports=0, in_ready=1.
  - A following pixel Y=128, U=128, V=128 still yields 128/128/128 with 5-cycle latency.
- Back-to-back stream of 8 random pixels with in_valid and out_ready held 1 → each result matches the reference formula, and accepts occur exactly 7 cycles apart.

Source files
------------

// File: rtl/yuv_to_rgb_unit.sv
// Serial YUV->RGB converter. One shared 9x9 signed multiplier is time-multiplexed by the FSM,
// and pixels move over valid/ready handshakes on both sides.
module yuv_to_rgb_unit #(
  parameter int BITS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] inportY,
  input  logic [BITS-1:0] inportU,
  input  logic [BITS-1:0] inportV,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BITS-1:0] outportR,
  output logic [BITS-1:0] outportG,
  output logic [BITS-1:0] outportB,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL_R  = 3'd1,
    ST_MUL_GU = 3'd2,
    ST_MUL_GV = 3'd3,
    ST_MUL_B  = 3'd4,
    ST_FIN    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // 359 and 454 do not fit a 9-bit signed operand, so they are split as 256 + 103 and 256 + 198;
  // the 256 part is a plain shift added alongside the product.
  localparam logic signed [8:0] COEF_R_LO = 9'sd103;
  localparam logic signed [8:0] COEF_GU   = 9'sd88;
  localparam logic signed [8:0] COEF_GV   = 9'sd183;
  localparam logic signed [8:0] COEF_B_LO = 9'sd198;

  state_t             state_r;
  state_t             state_next_s;
  logic        [7:0]  y_r;
  logic signed [8:0]  du_r;
  logic signed [8:0]  dv_r;
  logic signed [17:0] acc_r_r;
  logic signed [17:0] acc_g_r;
  logic signed [17:0] acc_b_r;
  logic        [7:0]  r_r;
  logic        [7:0]  g_r;
  logic        [7:0]  b_r;
  logic               out_valid_r;

  logic signed [8:0]  mul_coef_s;
  logic signed [8:0]  mul_opnd_s;
  logic signed [17:0] mul_prod_s;
  logic signed [17:0] du_x256_s;
  logic signed [17:0] dv_x256_s;
  logic signed [17:0] y_ext_s;
  logic signed [17:0] r_sum_s;
  logic signed [17:0] g_sum_s;
  logic signed [17:0] b_sum_s;
  logic               unused_hi_bits_s;

  function automatic logic [7:0] clamp_u8(input logic signed [17:0] v);
    logic [7:0] res;
    if (v < 18'sd0) begin
      res = 8'd0;
    end else if (v > 18'sd255) begin
      res = 8'd255;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

  assign unused_hi_bits_s = ^{inportY[BITS-1:8], inportU[BITS-1:8], inportV[BITS-1:8]};

  assign mul_prod_s = mul_coef_s * mul_opnd_s;
  assign du_x256_s  = {du_r[8], du_r, 8'd0};
  assign dv_x256_s  = {dv_r[8], dv_r, 8'd0};
  assign y_ext_s    = {10'd0, y_r};
  assign r_sum_s    = y_ext_s + (acc_r_r >>> 8);
  assign g_sum_s    = y_ext_s - (acc_g_r >>> 8);
  assign b_sum_s    = y_ext_s + (acc_b_r >>> 8);

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = out_valid_r;
  assign outportR  = {{(BITS-8){1'b0}}, r_r};
  assign outportG  = {{(BITS-8){1'b0}}, g_r};
  assign outportB  = {{(BITS-8){1'b0}}, b_r};

  // Multiplier operand selection by FSM state
  always_comb begin
    mul_coef_s = 9'sd0;
    mul_opnd_s = 9'sd0;
    case (state_r)
      ST_MUL_R:  begin mul_coef_s = COEF_R_LO; mul_opnd_s = dv_r; end
      ST_MUL_GU: begin mul_coef_s = COEF_GU;   mul_opnd_s = du_r; end
      ST_MUL_GV: begin mul_coef_s = COEF_GV;   mul_opnd_s = dv_r; end
      ST_MUL_B:  begin mul_coef_s = COEF_B_LO; mul_opnd_s = du_r; end
      default:   begin mul_coef_s = 9'sd0;     mul_opnd_s = 9'sd0; end
    endcase
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_MUL_R;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL_R:  state_next_s = ST_MUL_GU;
      ST_MUL_GU: state_next_s = ST_MUL_GV;
      ST_MUL_GV: state_next_s = ST_MUL_B;
      ST_MUL_B:  state_next_s = ST_FIN;
      ST_FIN:    state_next_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand latch, term accumulation, clamp and output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      y_r         <= 8'd0;
      du_r        <= 9'sd0;
      dv_r        <= 9'sd0;
      acc_r_r     <= 18'sd0;
      acc_g_r     <= 18'sd0;
      acc_b_r     <= 18'sd0;
      r_r         <= 8'd0;
      g_r         <= 8'd0;
      b_r         <= 8'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            y_r  <= inportY[7:0];
            du_r <= {1'b0, inportU[7:0]} - 9'd128;
            dv_r <= {1'b0, inportV[7:0]} - 9'd128;
          end
        end
        ST_MUL_R:  acc_r_r <= dv_x256_s + mul_prod_s;
        ST_MUL_GU: acc_g_r <= mul_prod_s;
        ST_MUL_GV: acc_g_r <= acc_g_r + mul_prod_s;
        ST_MUL_B:  acc_b_r <= du_x256_s + mul_prod_s;
        ST_FIN: begin
          r_r         <= clamp_u8(r_sum_s);
          g_r         <= clamp_u8(g_sum_s);
          b_r         <= clamp_u8(b_sum_s);
          out_valid_r <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_yuv_to_rgb_unit.sv
// Randomized and directed bench for yuv_to_rgb_unit, checked every cycle against a
// transaction-level reference model of the conversion formulas and handshake timing.
module tb_yuv_to_rgb_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] in_y, in_u, in_v;
  logic       in_valid, in_ready;
  logic [8:0] out_r, out_g, out_b;
  logic       out_valid, out_ready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model state
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cnt = 0;
  int          m_r = 0, m_g = 0, m_b = 0;
  logic [23:0] m_pend = 24'd0;
  int          acc_q[$];

  yuv_to_rgb_unit #(.BITS(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .inportY(in_y), .inportU(in_u), .inportV(in_v),
    .in_valid(in_valid), .in_ready(in_ready),
    .outportR(out_r), .outportG(out_g), .outportB(out_b),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp8(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic logic [23:0] ref_rgb(input int yy, input int uu, input int vv);
    int du, dv, r, g, b;
    du = uu - 128;
    dv = vv - 128;
    r = clamp8(yy + ((359 * dv) >>> 8));
    g = clamp8(yy - ((88 * du + 183 * dv) >>> 8));
    b = clamp8(yy + ((454 * du) >>> 8));
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // Reference model: idle / computing (5 edges) / holding result until out_ready
  always @(posedge clk) begin
    cyc++;
    chk_en = 1'b1;
    if (rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
      m_r = 0; m_g = 0; m_b = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_cnt = 0;
        m_pend = ref_rgb(int'(in_y[7:0]), int'(in_u[7:0]), int'(in_v[7:0]));
      end
    end else if (!m_valid) begin
      m_cnt++;
      if (m_cnt == 5) begin
        m_valid = 1'b1;
        m_r = int'(m_pend[23:16]);
        m_g = int'(m_pend[15:8]);
        m_b = int'(m_pend[7:0]);
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_busy = 1'b0;
    end
  end

  // Per-cycle compare against the model, plus DUT accept-time log
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_busy ? 0 : 1);
      check("out_valid", out_valid, m_valid ? 1 : 0);
      check("outportR", out_r, m_r);
      check("outportG", out_g, m_g);
      check("outportB", out_b, m_b);
      if (!rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel_lit(input string nm, input int yy, input int uu, input int vv,
                           input int er, input int eg, input int eb);
    int n;
    in_y = yy[8:0]; in_u = uu[8:0]; in_v = vv[8:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      check({nm, "_busy_in_ready"}, in_ready, 0);
      tick();
      n++;
    end
    check({nm, "_latency"}, n, 5);
    check({nm, "_R"}, out_r, er);
    check({nm, "_G"}, out_g, eg);
    check({nm, "_B"}, out_b, eb);
    check({nm, "_done_in_ready"}, in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_hs_out_valid"}, out_valid, 0);
    check({nm, "_hs_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [23:0] pin;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_y = 9'd0; in_u = 9'd0; in_v = 9'd0;
    tick(); tick();
    rst_n = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_R", out_r, 0);

    // pin the model on hand-computed values
    pin = ref_rgb(76, 84, 255);
    check("model_76_84_255", pin, {8'd254, 8'd1, 8'd0});
    pin = ref_rgb(0, 0, 0);
    check("model_0_0_0", pin, {8'd0, 8'd136, 8'd0});

    pixel_lit("grey", 128, 128, 128, 128, 128, 128);
    pixel_lit("floor_low", 76, 84, 255, 254, 1, 0);
    pixel_lit("high", 255, 255, 255, 255, 121, 255);
    pixel_lit("zero", 0, 0, 0, 0, 136, 0);
    pixel_lit("bit8", 9'h180, 9'h180, 9'h180, 128, 128, 128);

    // reset while in MUL_GV
    in_y = 9'd50; in_u = 9'd200; in_v = 9'd30;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_R", out_r, 0);
    check("midrst_G", out_g, 0);
    check("midrst_B", out_b, 0);
    check("midrst_in_ready", in_ready, 1);
    pixel_lit("after_rst", 128, 128, 128, 128, 128, 128);

    // backpressure: result held for 10 cycles while inputs churn
    in_y = 9'd76; in_u = 9'd84; in_v = 9'd255;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_y = 9'($urandom_range(0, 511));
      in_u = 9'($urandom_range(0, 511));
      in_v = 9'($urandom_range(0, 511));
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_R", out_r, 254);
      check("bp_G", out_g, 1);
      check("bp_B", out_b, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // back-to-back stream of 8 random pixels
    acc_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 200 && acc_q.size() < 8; i++) begin
      in_y = 9'($urandom_range(0, 511));
      in_u = 9'($urandom_range(0, 511));
      in_v = 9'($urandom_range(0, 511));
      tick();
    end
    in_valid = 1'b0;
    check("stream_accepts", acc_q.size(), 8);
    for (int i = 1; i < acc_q.size(); i++) begin
      check("stream_spacing", acc_q[i] - acc_q[i-1], 7);
    end
    for (int i = 0; i < 10; i++) tick();

    // free-running random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_y = 9'($urandom_range(0, 511));
      in_u = 9'($urandom_range(0, 511));
      in_v = 9'($urandom_range(0, 511));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
